// File: rtl/control_mc_v2.sv
// Multi-cycle MIPS32 control FSM: decodes state/op/func/zero/mem_ready into datapath
// enables and selects, with a bounded memory wait and a sticky trap state.
module control_mc_v2 #(
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned MEM_WAIT_EN = 1,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               IRWrite,
  output logic               MDRWrite,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         RegDst,
  output logic               RegWrite,
  output logic               RegAWrite,
  output logic               RegBWrite,
  output logic               ALUSrcA,
  output logic [2:0]         ALUSrcB,
  output logic               ALUOutWrite,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [2:0]         PCSrc,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_IF       = 4'd0,  S_ID     = 4'd1,  S_EXE_R  = 4'd2,  S_EXE_I  = 4'd3,
    S_EXE_BR   = 4'd4,  S_EXE_ADDR = 4'd5, S_EXE_J = 4'd6,  S_EXE_JR = 4'd7,
    S_MEM_LW   = 4'd8,  S_MEM_SW = 4'd9,  S_WB_R   = 4'd10, S_WB_I   = 4'd11,
    S_WB_LW    = 4'd12, S_TRAP   = 4'd15
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(4'd0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(4'd1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(4'd2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(4'd3);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(4'd4);
  localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(4'd5);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4'd6);
  localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(4'd7);
  localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(4'd8);

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101, OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011, OP_SW   = 6'b101011, OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011, FN_JR   = 6'b001000;

  state_t             state_r, state_next_s;
  logic [1:0]         cause_r, cause_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               mem_ready_s, waiting_s, timeout_s;
  logic               r_legal_s, r_shift_s;
  logic [ALUOP_W-1:0] r_aluop_s;
  logic               ir_write_s, mdr_write_s, reg_write_s, rega_write_s, regb_write_s;
  logic               aluout_write_s, pc_write_s, mem_read_s, mem_write_s;

  assign mem_ready_s = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign waiting_s   = ((state_r == S_IF) || (state_r == S_MEM_LW) || (state_r == S_MEM_SW))
                       && !mem_ready_s;
  assign timeout_s   = (TIMEOUT != 0) && waiting_s && (cnt_r == CNT_W'(TIMEOUT));

  // R-type function decode: ALU operation, shift-amount select and legality
  always_comb begin
    r_legal_s = 1'b1;
    r_shift_s = 1'b0;
    r_aluop_s = ALU_ADD;
    case (func)
      6'b100000: r_aluop_s = ALU_ADD;
      6'b100010: r_aluop_s = ALU_SUB;
      6'b100100: r_aluop_s = ALU_AND;
      6'b100101: r_aluop_s = ALU_OR;
      6'b100110: r_aluop_s = ALU_XOR;
      6'b100111: r_aluop_s = ALU_NOR;
      6'b101010: r_aluop_s = ALU_SLT;
      6'b000000: begin r_aluop_s = ALU_SLL; r_shift_s = 1'b1; end
      6'b000010: begin r_aluop_s = ALU_SRL; r_shift_s = 1'b1; end
      default:   r_legal_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_IF;
    else     state_r <= state_next_s;
  end

  // Trap cause capture and per-access wait counter (cleared on every state change)
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_r <= 2'b00;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      cause_r <= cause_next_s;
      if (state_next_s != state_r)                    cnt_r <= {CNT_W{1'b0}};
      else if (waiting_s && (cnt_r != {CNT_W{1'b1}})) cnt_r <= cnt_r + CNT_W'(1);
      else                                            cnt_r <= cnt_r;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    cause_next_s = cause_r;
    case (state_r)
      S_IF: begin
        if (mem_ready_s)    state_next_s = S_ID;
        else if (timeout_s) begin state_next_s = S_TRAP; cause_next_s = 2'b11; end
        else                state_next_s = S_IF;
      end
      S_ID: begin
        case (op)
          OP_RTYPE:                 state_next_s = (func == FN_JR) ? S_EXE_JR : S_EXE_R;
          OP_ADDI, OP_ANDI, OP_ORI: state_next_s = S_EXE_I;
          OP_BEQ, OP_BNE:           state_next_s = S_EXE_BR;
          OP_LW, OP_SW:             state_next_s = S_EXE_ADDR;
          OP_J, OP_JAL:             state_next_s = S_EXE_J;
          default: begin state_next_s = S_TRAP; cause_next_s = 2'b01; end
        endcase
      end
      S_EXE_R: begin
        if (r_legal_s) state_next_s = S_WB_R;
        else begin state_next_s = S_TRAP; cause_next_s = 2'b10; end
      end
      S_EXE_I:    state_next_s = S_WB_I;
      S_EXE_ADDR: state_next_s = (op == OP_LW) ? S_MEM_LW : S_MEM_SW;
      S_MEM_LW: begin
        if (mem_ready_s)    state_next_s = S_WB_LW;
        else if (timeout_s) begin state_next_s = S_TRAP; cause_next_s = 2'b11; end
        else                state_next_s = S_MEM_LW;
      end
      S_MEM_SW: begin
        if (mem_ready_s)    state_next_s = S_IF;
        else if (timeout_s) begin state_next_s = S_TRAP; cause_next_s = 2'b11; end
        else                state_next_s = S_MEM_SW;
      end
      S_EXE_BR, S_EXE_J, S_EXE_JR, S_WB_R, S_WB_I, S_WB_LW: state_next_s = S_IF;
      S_TRAP:  state_next_s = S_TRAP;
      default: state_next_s = S_IF;
    endcase
  end

  // Output decode; enables are gated by reset below
  always_comb begin
    ir_write_s = 1'b0; mdr_write_s = 1'b0; reg_write_s = 1'b0; rega_write_s = 1'b0;
    regb_write_s = 1'b0; aluout_write_s = 1'b0; pc_write_s = 1'b0;
    mem_read_s = 1'b0; mem_write_s = 1'b0;
    MemtoReg = 2'b00; RegDst = 2'b00; ALUSrcA = 1'b0; ALUSrcB = 3'b000;
    ALUop = ALU_ADD; PCSrc = 3'b000; IorD = 1'b0;
    case (state_r)
      S_IF: begin
        mem_read_s = 1'b1; ALUSrcB = 3'b100;
        ir_write_s = mem_ready_s; pc_write_s = mem_ready_s;
      end
      S_ID: begin
        rega_write_s = 1'b1; regb_write_s = 1'b1; aluout_write_s = 1'b1; ALUSrcB = 3'b011;
      end
      S_EXE_R: begin
        ALUSrcA = 1'b1; aluout_write_s = 1'b1; ALUop = r_aluop_s;
        ALUSrcB = r_shift_s ? 3'b001 : 3'b000;
      end
      S_EXE_I: begin
        ALUSrcA = 1'b1; aluout_write_s = 1'b1;
        ALUSrcB = (op == OP_ADDI) ? 3'b010 : 3'b101;
        ALUop   = (op == OP_ANDI) ? ALU_AND : ((op == OP_ORI) ? ALU_OR : ALU_ADD);
      end
      S_EXE_BR: begin
        ALUSrcA = 1'b1; ALUop = ALU_SUB; PCSrc = 3'b001;
        pc_write_s = (op == OP_BNE) ? !zero : zero;
      end
      S_EXE_ADDR: begin
        ALUSrcA = 1'b1; ALUSrcB = 3'b010; aluout_write_s = 1'b1;
      end
      S_EXE_J: begin
        PCSrc = 3'b010; pc_write_s = 1'b1;
        if (op == OP_JAL) begin reg_write_s = 1'b1; RegDst = 2'b10; MemtoReg = 2'b10; end
        else              begin reg_write_s = 1'b0; RegDst = 2'b00; MemtoReg = 2'b00; end
      end
      S_EXE_JR: begin PCSrc = 3'b011; pc_write_s = 1'b1; end
      S_MEM_LW: begin mem_read_s = 1'b1; IorD = 1'b1; mdr_write_s = mem_ready_s; end
      S_MEM_SW: begin mem_write_s = 1'b1; IorD = 1'b1; end
      S_WB_R:   begin reg_write_s = 1'b1; RegDst = 2'b01; end
      S_WB_I:   reg_write_s = 1'b1;
      S_WB_LW:  begin reg_write_s = 1'b1; MemtoReg = 2'b01; end
      default:  ALUop = ALU_ADD;
    endcase
  end

  assign IRWrite     = ir_write_s     & ~rst;
  assign MDRWrite    = mdr_write_s    & ~rst;
  assign RegWrite    = reg_write_s    & ~rst;
  assign RegAWrite   = rega_write_s   & ~rst;
  assign RegBWrite   = regb_write_s   & ~rst;
  assign ALUOutWrite = aluout_write_s & ~rst;
  assign PCWrite     = pc_write_s     & ~rst;
  assign MemRead     = mem_read_s     & ~rst;
  assign MemWrite    = mem_write_s    & ~rst;
  assign trap        = (state_r == S_TRAP);
  assign trap_cause  = cause_r;
  assign state       = state_r;

endmodule

// File: tb/tb_control_mc_v2.sv
// Randomized scoreboard bench for control_mc_v2: an instruction-level model queues the
// expected control word for each cycle and a negedge monitor compares the DUT against it.
module tb_control_mc_v2;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst, zero, mem_ready;
  logic [5:0] op, func;
  logic IRWrite, MDRWrite, RegWrite, RegAWrite, RegBWrite, ALUSrcA, ALUOutWrite;
  logic PCWrite, IorD, MemRead, MemWrite, trap;
  logic [1:0] MemtoReg, RegDst, trap_cause;
  logic [2:0] ALUSrcB, PCSrc;
  logic [3:0] ALUop, state;

  always #5 clk = ~clk;

  control_mc_v2 #(.ALUOP_W(4), .MEM_WAIT_EN(1), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .MDRWrite(MDRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .RegAWrite(RegAWrite), .RegBWrite(RegBWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOutWrite(ALUOutWrite), .ALUop(ALUop), .PCSrc(PCSrc),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .trap(trap),
    .trap_cause(trap_cause), .state(state));

  typedef struct packed {
    logic ir, mdr; logic [1:0] m2r, rdst; logic rw, ra, rb, srca; logic [2:0] srcb;
    logic aow; logic [3:0] aluop; logic [2:0] pcsrc; logic pcw, iord, mr, mw, trp;
    logic [1:0] cause; logic [3:0] st;
  } ctl_t;

  ctl_t  exp_q[$], mask_q[$];
  string name_q[$];
  int    vectors = 0, miscompares = 0;
  int    br_zero = -1;
  ctl_t  full_m, rst_m;
  logic [5:0] op_tab [0:11] = '{6'd0, 6'd0, 6'd0, 6'b001000, 6'b001100, 6'b001101,
                                6'b000100, 6'b000101, 6'b100011, 6'b101011, 6'b000010, 6'b000011};
  logic [5:0] fn_tab [0:9]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b001000};

  // Monitor: pop one expected control word per cycle and compare away from the clock edge
  always @(negedge clk) begin
    logic [31:0] a, e, m;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = mask_q.pop_front(); n = name_q.pop_front();
      a = {IRWrite, MDRWrite, MemtoReg, RegDst, RegWrite, RegAWrite, RegBWrite, ALUSrcA,
           ALUSrcB, ALUOutWrite, ALUop, PCSrc, PCWrite, IorD, MemRead, MemWrite, trap,
           trap_cause, state};
      vectors++;
      if ((a & m) !== (e & m)) begin
        miscompares++;
        $display("FAIL %s @%0t: got %h expected %h (mask %h)", n, $time, a, e, m);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic ctl_t st(input int s);
    ctl_t c = '0;
    c.st = 4'(s);
    return c;
  endfunction

  // Maps an R-type function code to its ALU operation code; returns -1 for an illegal code
  function automatic int rcode(input logic [5:0] f);
    case (f)
      6'b100000: return 0;  6'b100010: return 1;  6'b100100: return 2;
      6'b100101: return 3;  6'b100110: return 4;  6'b100111: return 5;
      6'b101010: return 6;  6'b000000: return 7;  6'b000010: return 8;
      default:   return -1;
    endcase
  endfunction

  function automatic int pick_delay();
    int r = $urandom_range(0, 19);
    return (r < 16) ? (r % 4) : (TO + r - 16);
  endfunction

  task automatic step(input logic r, input logic mr, input logic zr, input ctl_t e,
                      input ctl_t m, input string n);
    rst = r; mem_ready = mr; zero = zr;
    exp_q.push_back(e); mask_q.push_back(m); name_q.push_back(n);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, rb(), rb(), '0, rst_m, "reset");
  endtask

  task automatic trap_tail(input logic [1:0] cause);
    ctl_t e = st(15);
    e.trp = 1'b1; e.cause = cause;
    for (int i = 0; i < 2 + $urandom_range(0, 2); i++) step(1'b0, rb(), rb(), e, full_m, "TRAP");
    do_reset(1 + $urandom_range(0, 1));
  endtask

  // d cycles without mem_ready, then a ready cycle; trapped when the wait exceeds TO
  task automatic wait_phase(input ctl_t ew, input ctl_t ed, input int d, input string n,
                            output bit trapped);
    trapped = 1'b0;
    for (int k = 0; k <= TO + 1; k++) begin
      if (k < d) begin
        step(1'b0, 1'b0, rb(), ew, full_m, n);
        if (k == TO) begin trapped = 1'b1; return; end
      end else begin
        step(1'b0, 1'b1, rb(), ed, full_m, n);
        return;
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int d_if,
                           input int d_mem, input bit rst_mid);
    ctl_t e, ed; bit tr; int code; logic zr;
    op = o; func = f;
    e = st(0); e.mr = 1'b1; e.srcb = 3'b100;
    ed = e; ed.ir = 1'b1; ed.pcw = 1'b1;
    wait_phase(e, ed, d_if, "IF", tr);
    if (tr) begin trap_tail(2'b11); return; end
    e = st(1); e.ra = 1'b1; e.rb = 1'b1; e.aow = 1'b1; e.srcb = 3'b011;
    step(1'b0, rb(), rb(), e, full_m, "ID");
    case (o)
      6'b000000: begin
        if (f == 6'b001000) begin
          e = st(7); e.pcsrc = 3'b011; e.pcw = 1'b1;
          step(1'b0, rb(), rb(), e, full_m, "EXE_JR");
        end else begin
          code = rcode(f);
          e = st(2); e.srca = 1'b1; e.aow = 1'b1;
          e.srcb  = (code == 7 || code == 8) ? 3'b001 : 3'b000;
          e.aluop = (code < 0) ? 4'd0 : 4'(code);
          step(1'b0, rb(), rb(), e, full_m, "EXE_R");
          if (code < 0) trap_tail(2'b10);
          else begin
            e = st(10); e.rw = 1'b1; e.rdst = 2'b01;
            step(1'b0, rb(), rb(), e, full_m, "WB_R");
          end
        end
      end
      6'b001000, 6'b001100, 6'b001101: begin
        e = st(3); e.srca = 1'b1; e.aow = 1'b1;
        e.srcb  = (o == 6'b001000) ? 3'b010 : 3'b101;
        e.aluop = (o == 6'b001000) ? 4'd0 : ((o == 6'b001100) ? 4'd2 : 4'd3);
        step(1'b0, rb(), rb(), e, full_m, "EXE_I");
        e = st(11); e.rw = 1'b1;
        step(1'b0, rb(), rb(), e, full_m, "WB_I");
      end
      6'b000100, 6'b000101: begin
        zr = (br_zero < 0) ? rb() : 1'(br_zero);
        e = st(4); e.srca = 1'b1; e.aluop = 4'd1; e.pcsrc = 3'b001;
        e.pcw = (o == 6'b000100) ? zr : ~zr;
        step(1'b0, rb(), zr, e, full_m, "EXE_BR");
      end
      6'b100011, 6'b101011: begin
        e = st(5); e.srca = 1'b1; e.srcb = 3'b010; e.aow = 1'b1;
        step(1'b0, rb(), rb(), e, full_m, "EXE_ADDR");
        if (o == 6'b100011) begin
          e = st(8); e.mr = 1'b1; e.iord = 1'b1; ed = e; ed.mdr = 1'b1;
          wait_phase(e, ed, d_mem, "MEM_LW", tr);
          if (tr) trap_tail(2'b11);
          else begin
            e = st(12); e.rw = 1'b1; e.m2r = 2'b01;
            step(1'b0, rb(), rb(), e, full_m, "WB_LW");
          end
        end else begin
          e = st(9); e.mw = 1'b1; e.iord = 1'b1;
          if (rst_mid) begin
            step(1'b0, 1'b0, rb(), e, full_m, "MEM_SW");
            do_reset(2);
          end else begin
            wait_phase(e, e, d_mem, "MEM_SW", tr);
            if (tr) trap_tail(2'b11);
          end
        end
      end
      6'b000010, 6'b000011: begin
        e = st(6); e.pcsrc = 3'b010; e.pcw = 1'b1;
        if (o == 6'b000011) begin e.rw = 1'b1; e.rdst = 2'b10; e.m2r = 2'b10; end
        step(1'b0, rb(), rb(), e, full_m, "EXE_J");
      end
      default: trap_tail(2'b01);
    endcase
  endtask

  initial begin
    logic [5:0] o, f;
    full_m = '1;
    rst_m = '0;
    rst_m.ir = 1'b1; rst_m.mdr = 1'b1; rst_m.rw = 1'b1; rst_m.ra = 1'b1; rst_m.rb = 1'b1;
    rst_m.aow = 1'b1; rst_m.pcw = 1'b1; rst_m.mr = 1'b1; rst_m.mw = 1'b1;
    rst = 1'b1; op = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1);
    run_instr(6'b101011, 6'd0, 0, 0, 1'b1);       // reset mid store
    run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);  // add
    run_instr(6'b100011, 6'd0, 0, 3, 1'b0);       // lw, 3 wait cycles
    br_zero = 0;
    run_instr(6'b000101, 6'd0, 0, 0, 1'b0);       // bne, zero=0
    run_instr(6'b000100, 6'd0, 0, 0, 1'b0);       // beq, zero=0
    br_zero = -1;
    run_instr(6'b000011, 6'd0, 1, 0, 1'b0);       // jal
    run_instr(6'b000000, 6'b001000, 2, 0, 1'b0);  // jr
    run_instr(6'b001000, 6'd0, TO, 0, 1'b0);      // ready exactly at the limit
    run_instr(6'b001000, 6'd0, TO + 1, 0, 1'b0);  // IF timeout
    run_instr(6'b101011, 6'd0, 0, TO + 1, 1'b0);  // store timeout
    run_instr(6'b111111, 6'd0, 0, 0, 1'b0);       // illegal op
    run_instr(6'b000000, 6'b111111, 0, 0, 1'b0);  // illegal func
    for (int i = 0; i < 300; i++) begin
      int sel = $urandom_range(0, 14);
      o = (sel < 12) ? op_tab[sel] : 6'($urandom_range(0, 63));
      f = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : fn_tab[$urandom_range(0, 9)];
      run_instr(o, f, pick_delay(), pick_delay(), 1'b0);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
